// File: rtl/display_arbiter_pkg.sv
// Shared constants for the display arbiter slice.
package display_arbiter_pkg;

  // Packed board width: 64 squares x 4-bit piece code. This matches the
  // display_board snapshot width.
  localparam int unsigned BOARD_WIDTH = 256;
  localparam int unsigned CASTLE_W    = 4;
  localparam int unsigned EP_W        = 4;

  // Returns v+1, wrapping to zero at n.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
  endfunction

endpackage

// File: rtl/display_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i.
module display_arbiter_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;

  // Scan N slots starting at the pointer and keep the first requester found.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = IW'((32'(ptr_i) + off) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Shares one board printer between NUM_REQ requesters: round-robin grant,
// snapshot latch, one-cycle display pulse, wait for done (or timeout), ack.
module display_arbiter
  import display_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned EVAL_WIDTH = 24,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*BOARD_WIDTH-1:0]    req_board,
  input  logic [NUM_REQ*CASTLE_W-1:0]       req_castle_mask,
  input  logic [NUM_REQ*EP_W-1:0]           req_en_passant_col,
  input  logic [NUM_REQ-1:0]                req_capture,
  input  logic [NUM_REQ-1:0]                req_white_in_check,
  input  logic [NUM_REQ-1:0]                req_black_in_check,
  input  logic [NUM_REQ-1:0]                req_thrice_rep,
  input  logic [NUM_REQ*EVAL_WIDTH-1:0]     req_eval,
  output logic [NUM_REQ-1:0]                req_ack,
  output logic [BOARD_WIDTH-1:0]            disp_board,
  output logic [CASTLE_W-1:0]               disp_castle_mask,
  output logic [EP_W-1:0]                   disp_en_passant_col,
  output logic                              disp_capture,
  output logic                              disp_white_in_check,
  output logic                              disp_black_in_check,
  output logic                              disp_thrice_rep,
  output logic signed [EVAL_WIDTH-1:0]      disp_eval,
  output logic                              disp_display,
  input  logic                              disp_done,
  output logic                              busy,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id,
  output logic                              timeout_err
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_WAIT, S_ACK} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]          grant_q, grant_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic                   fire_q, fire_d;
  logic                   terr_q, terr_d;
  logic [BOARD_WIDTH-1:0] board_q, board_d;
  logic [CASTLE_W-1:0]    castle_q, castle_d;
  logic [EP_W-1:0]        ep_q, ep_d;
  logic [3:0]             flags_q, flags_d;   // {capture, white_chk, black_chk, thrice}
  logic [EVAL_WIDTH-1:0]  eval_q, eval_d;

  logic                   pick_valid;
  logic [IW-1:0]          pick_idx;
  logic [31:0]            pick_sel;

  display_arbiter_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign pick_sel = 32'(pick_idx);

  // Next-state logic: grant and latch in IDLE, pulse in FIRE, wait/timeout, ack.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    ack_d    = '0;
    fire_d   = 1'b0;
    terr_d   = terr_q;
    board_d  = board_q;
    castle_d = castle_q;
    ep_d     = ep_q;
    flags_d  = flags_q;
    eval_d   = eval_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d  = S_FIRE;
          grant_d  = pick_idx;
          fire_d   = 1'b1;
          board_d  = req_board[pick_sel*BOARD_WIDTH +: BOARD_WIDTH];
          castle_d = req_castle_mask[pick_sel*CASTLE_W +: CASTLE_W];
          ep_d     = req_en_passant_col[pick_sel*EP_W +: EP_W];
          flags_d  = {req_capture[pick_idx], req_white_in_check[pick_idx],
                      req_black_in_check[pick_idx], req_thrice_rep[pick_idx]};
          eval_d   = req_eval[pick_sel*EVAL_WIDTH +: EVAL_WIDTH];
        end
      end
      S_FIRE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (disp_done) begin
          ack_d[grant_q] = 1'b1;
          state_d        = S_ACK;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          terr_d         = 1'b1;
          ack_d[grant_q] = 1'b1;
          state_d        = S_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACK: begin
        rr_ptr_d = IW'(wrap_inc(32'(grant_q), NUM_REQ));
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      ack_q    <= '0;
      fire_q   <= 1'b0;
      terr_q   <= 1'b0;
      board_q  <= '0;
      castle_q <= '0;
      ep_q     <= '0;
      flags_q  <= '0;
      eval_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      fire_q   <= fire_d;
      terr_q   <= terr_d;
      board_q  <= board_d;
      castle_q <= castle_d;
      ep_q     <= ep_d;
      flags_q  <= flags_d;
      eval_q   <= eval_d;
    end
  end

  assign req_ack             = ack_q;
  assign disp_board          = board_q;
  assign disp_castle_mask    = castle_q;
  assign disp_en_passant_col = ep_q;
  assign disp_capture        = flags_q[3];
  assign disp_white_in_check = flags_q[2];
  assign disp_black_in_check = flags_q[1];
  assign disp_thrice_rep     = flags_q[0];
  assign disp_eval           = eval_q;
  assign disp_display        = fire_q;
  assign busy                = (state_q != S_IDLE);
  assign grant_id            = grant_q;
  assign timeout_err         = terr_q;

endmodule
